// File: rtl/result_requant_drain_if.sv
// Row-stream bus from the requant drain stage toward activation/writeback.
// valid/ready: a row transfers on a rising edge where o_valid && i_ready; while o_valid is high and
// i_ready low the master holds o_row, o_rowIdx and o_last stable.
interface result_requant_drain_if #(
  parameter int N = 16
) ();
  localparam int IW = $clog2(N);

  logic [N-1:0][7:0] o_row;
  logic [IW-1:0]     o_rowIdx;
  logic              o_valid;
  logic              i_ready;
  logic              o_last;

  modport master (output o_row, output o_rowIdx, output o_valid, output o_last, input i_ready);
  modport slave  (input o_row, input o_rowIdx, input o_valid, input o_last, output i_ready);
endinterface

// File: rtl/result_requant_drain.sv
// Captures an N x N int32 tile from the systolic array, requantizes it to int8 with latched
// scale/shift/zero point, and drains it one row per beat over a valid/ready bus.
module result_requant_drain #(
  parameter int N       = 16,
  parameter int SCALE_W = 16
) (
  input  logic                      i_clk,
  input  logic                      i_arst_n,
  input  logic [N-1:0][N-1:0][31:0] i_c,
  input  logic                      i_validResult,
  input  logic [SCALE_W-1:0]        i_scale,
  input  logic [4:0]                i_shift,
  input  logic [7:0]                i_zeroPoint,
  result_requant_drain_if.master    rows_o,
  output logic                      o_busy,
  output logic                      o_overrun,
  output logic [1:0]                o_state
);

  localparam int IW = $clog2(N);
  // Two guard bits above the product keep the rounding add and zero-point add from overflowing.
  localparam int PW = 32 + SCALE_W + 2;
  localparam logic signed [PW-1:0] SAT_HI = PW'(127);
  localparam logic signed [PW-1:0] SAT_LO = -PW'(128);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  state_t                    state_q;
  logic [N-1:0][N-1:0][31:0] tile_q;
  logic [SCALE_W-1:0]        scale_q;
  logic [4:0]                shift_q;
  logic [7:0]                zp_q;
  logic [N-1:0][7:0]         row_q;
  logic [IW-1:0]             idx_q;
  logic                      valid_q;
  logic                      last_q;
  logic                      overrun_q;

  logic [IW-1:0]             sel_d;
  logic [N-1:0][7:0]         row_d;
  logic                      capture;
  logic                      accept;

  function automatic logic [7:0] requant(input logic [31:0]        c,
                                         input logic [SCALE_W-1:0] sc,
                                         input logic [4:0]         s,
                                         input logic [7:0]         zp);
    logic signed [PW-1:0] c_x, sc_x, p, rnd, q, y;
    c_x  = PW'($signed(c));
    sc_x = $signed(PW'(sc));
    p    = c_x * sc_x;
    rnd  = (s == 5'd0) ? '0 : (PW'(1) << (s - 5'd1));
    q    = (p + rnd) >>> s;
    y    = q + PW'($signed(zp));
    if (y > SAT_HI)      return 8'h7F;
    else if (y < SAT_LO) return 8'h80;
    else                 return y[7:0];
  endfunction

  assign capture = (state_q == S_IDLE) && i_validResult;
  assign accept  = valid_q && rows_o.i_ready;

  // The row being loaded next: row 0 on FILL, otherwise the successor of the presented row.
  always_comb begin
    sel_d = '0;
    if (state_q == S_STREAM && idx_q != IW'(N - 1)) sel_d = idx_q + IW'(1);
    row_d = '0;
    for (int j = 0; j < N; j++) begin
      row_d[j] = requant(tile_q[sel_d][j], scale_q, shift_q, zp_q);
    end
  end

  always_ff @(posedge i_clk) begin
    if (capture) begin
      tile_q  <= i_c;
      scale_q <= i_scale;
      shift_q <= i_shift;
      zp_q    <= i_zeroPoint;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= i_validResult && (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (i_validResult) state_q <= S_FILL;
        end
        S_FILL: begin
          row_q   <= row_d;
          idx_q   <= '0;
          valid_q <= 1'b1;
          last_q  <= (N == 1);
          state_q <= S_STREAM;
        end
        S_STREAM: begin
          if (accept) begin
            if (idx_q == IW'(N - 1)) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              row_q  <= row_d;
              idx_q  <= idx_q + IW'(1);
              last_q <= ((idx_q + IW'(1)) == IW'(N - 1));
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rows_o.o_row    = row_q;
  assign rows_o.o_rowIdx = idx_q;
  assign rows_o.o_valid  = valid_q;
  assign rows_o.o_last   = last_q;
  assign o_busy          = (state_q != S_IDLE);
  assign o_overrun       = overrun_q;
  assign o_state         = state_q;

endmodule

// File: tb/tb_result_requant_drain.sv
// Bench for result_requant_drain: requant vector table, basic/backpressure/random tiles,
// overrun and mid-stream reset sequences, all scored against a plain-arithmetic model.
module tb_result_requant_drain;

  localparam int N  = 16;
  localparam int SW = 16;
  localparam int IW = 4;
  localparam int W  = N * 8 + IW + 1;

  typedef logic [N-1:0][N-1:0][31:0] tile_t;
  typedef logic [N-1:0][7:0]         row_t;

  typedef struct {
    logic signed [31:0] c;
    logic [SW-1:0]      scale;
    logic [4:0]         shift;
    logic signed [7:0]  zp;
    logic signed [7:0]  exp;
  } vec_t;

  logic          i_clk = 1'b0;
  logic          i_arst_n = 1'b0;
  tile_t         i_c = '0;
  logic          i_validResult = 1'b0;
  logic [SW-1:0] i_scale = '0;
  logic [4:0]    i_shift = '0;
  logic [7:0]    i_zeroPoint = '0;
  logic          o_busy;
  logic          o_overrun;
  logic [1:0]    dbg_state;

  result_requant_drain_if #(.N(N)) rows ();

  result_requant_drain #(.N(N), .SCALE_W(SW)) dut (
    .i_clk         (i_clk),
    .i_arst_n      (i_arst_n),
    .i_c           (i_c),
    .i_validResult (i_validResult),
    .i_scale       (i_scale),
    .i_shift       (i_shift),
    .i_zeroPoint   (i_zeroPoint),
    .rows_o        (rows),
    .o_busy        (o_busy),
    .o_overrun     (o_overrun),
    .o_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] exp_q[$];
  int           ready_mode = 0;
  vec_t         vecs[10];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout/unexpected expected event", name);
  endtask

  // Reference requant: floor((c*scale + half) / 2^s) + zp, clamped to int8.
  function automatic logic [7:0] model(input logic [31:0] c, input logic [SW-1:0] sc,
                                       input int s, input logic [7:0] zp);
    longint p, num, d, q, y;
    p   = longint'($signed(c)) * longint'(sc);
    num = p + ((s > 0) ? (longint'(1) << (s - 1)) : 64'sd0);
    d   = longint'(1) << s;
    q   = num / d;
    if (num < 0 && (num % d) != 0) q = q - 1;
    y   = q + longint'($signed(zp));
    if (y > 127)  y = 127;
    if (y < -128) y = -128;
    return y[7:0];
  endfunction

  function automatic logic [W-1:0] pack_row(input int r, input row_t row);
    logic [IW-1:0] idx;
    idx = IW'(r);
    return {(r == N - 1), idx, row};
  endfunction

  function automatic tile_t rand_tile(input int kind);
    tile_t t;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        t[i][j] = (kind == 0) ? (32'($urandom_range(0, 4000)) - 32'd2000) : $urandom();
    return t;
  endfunction

  task automatic push_model(input tile_t t, input logic [SW-1:0] sc, input logic [4:0] sh,
                            input logic [7:0] zp);
    row_t row;
    for (int r = 0; r < N; r++) begin
      for (int j = 0; j < N; j++) row[j] = model(t[r][j], sc, int'(sh), zp);
      exp_q.push_back(pack_row(r, row));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Pulse is sampled on the edge after the call starts; inputs are scrambled right after.
  task automatic pulse(input tile_t t, input logic [SW-1:0] sc, input logic [4:0] sh,
                       input logic [7:0] zp);
    @(posedge i_clk); #1;
    i_c = t; i_scale = sc; i_shift = sh; i_zeroPoint = zp; i_validResult = 1'b1;
    @(posedge i_clk); #1;
    i_validResult = 1'b0;
    i_c = rand_tile(1);
    i_scale = SW'($urandom());
    i_shift = 5'($urandom());
    i_zeroPoint = 8'($urandom());
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge i_clk);
      if (!o_busy && exp_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      fail_now(name);
      exp_q.delete();
    end
  endtask

  task automatic wait_row(input int idx, input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge i_clk);
      if (rows.o_valid && rows.o_rowIdx == IW'(idx)) done = 1'b1;
    end
    if (!done) fail_now(name);
  endtask

  initial begin
    logic [5:0] pat;
    int pidx;
    pat = 6'b100101;
    pidx = 0;
    rows.i_ready = 1'b1;
    forever begin
      @(posedge i_clk); #1;
      case (ready_mode)
        1:       begin rows.i_ready = pat[5 - pidx]; pidx = (pidx + 1) % 6; end
        2:       rows.i_ready = ($urandom_range(0, 3) != 0);
        default: rows.i_ready = 1'b1;
      endcase
    end
  end

  // ---------------- monitor: ordered rows and stall stability ----------------
  initial begin
    logic         stalled;
    logic [W-1:0] held, cur;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge i_clk);
      cur = {rows.o_last, rows.o_rowIdx, rows.o_row};
      if (!i_arst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) check("stall_hold", {rows.o_valid, cur}, {1'b1, held});
        if (rows.o_valid && rows.i_ready) begin
          if (exp_q.size() == 0) fail_now("unexpected_row");
          else check("row", cur, exp_q.pop_front());
        end
        stalled = rows.o_valid && !rows.i_ready;
        held = cur;
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    tile_t         t, tb2;
    logic [SW-1:0] sc;
    logic [4:0]    sh;
    logic [7:0]    zp;
    row_t          vrow;

    vecs[0] = '{c: 32'sd5,           scale: 16'd1,     shift: 5'd1,  zp: 8'sd0,   exp: 8'sd3};
    vecs[1] = '{c: -32'sd5,          scale: 16'd1,     shift: 5'd1,  zp: 8'sd0,   exp: -8'sd2};
    vecs[2] = '{c: -32'sd6,          scale: 16'd1,     shift: 5'd2,  zp: 8'sd0,   exp: -8'sd1};
    vecs[3] = '{c: 32'sd7,           scale: 16'd1,     shift: 5'd0,  zp: -8'sd10, exp: -8'sd3};
    vecs[4] = '{c: 32'sd1000,        scale: 16'd3,     shift: 5'd4,  zp: 8'sd0,   exp: 8'sd127};
    vecs[5] = '{c: -32'sd100000,     scale: 16'd1,     shift: 5'd0,  zp: 8'sd0,   exp: -8'sd128};
    vecs[6] = '{c: 32'sd20,          scale: 16'd1,     shift: 5'd0,  zp: 8'sd120, exp: 8'sd127};
    vecs[7] = '{c: 32'sh7FFFFFFF,    scale: 16'd65535, shift: 5'd31, zp: 8'sd0,   exp: 8'sd127};
    vecs[8] = '{c: 32'sh80000000,    scale: 16'd65535, shift: 5'd31, zp: 8'sd0,   exp: -8'sd128};
    vecs[9] = '{c: -32'sd3,          scale: 16'd1,     shift: 5'd1,  zp: 8'sd0,   exp: -8'sd1};

    // reset values
    #12;
    check("rst_valid",   rows.o_valid,  0);
    check("rst_last",    rows.o_last,   0);
    check("rst_busy",    o_busy,        0);
    check("rst_overrun", o_overrun,     0);
    check("rst_row",     rows.o_row,    0);
    check("rst_rowidx",  rows.o_rowIdx, 0);
    @(posedge i_clk); #3;
    i_arst_n = 1'b1;
    repeat (2) @(negedge i_clk);

    // basic stream: c[i][j] = i - j, identity requant, latency and back-to-back rows
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) t[i][j] = 32'(i - j);
    push_model(t, 16'd1, 5'd0, 8'd0);
    pulse(t, 16'd1, 5'd0, 8'd0);
    @(negedge i_clk);
    check("fill_valid",   rows.o_valid, 0);
    check("fill_busy",    o_busy,       1);
    check("fill_overrun", o_overrun,    0);
    @(negedge i_clk);
    check("first_valid",  rows.o_valid,   1);
    check("first_rowidx", rows.o_rowIdx,  0);
    repeat (N) @(negedge i_clk);
    check("basic_drained", exp_q.size(), 0);
    check("basic_valid",   rows.o_valid, 0);
    check("basic_busy",    o_busy,       0);

    // requant vector table: every element of the tile holds the vector's c
    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) t[i][j] = vecs[v].c;
      vrow = {N{vecs[v].exp}};
      for (int r = 0; r < N; r++) exp_q.push_back(pack_row(r, vrow));
      pulse(t, vecs[v].scale, vecs[v].shift, vecs[v].zp);
      wait_idle(100, "vec_drain");
    end

    // backpressure pattern 1,0,0,1,0,1...
    ready_mode = 1;
    t = rand_tile(0);
    push_model(t, 16'd37, 5'd3, 8'd4);
    pulse(t, 16'd37, 5'd3, 8'd4);
    wait_idle(200, "bp_drain");
    ready_mode = 0;

    // overrun while row 5 is presented
    t  = rand_tile(0);
    sc = 16'($urandom_range(1, 200));
    sh = 5'($urandom_range(0, 8));
    zp = 8'($urandom());
    push_model(t, sc, sh, zp);
    pulse(t, sc, sh, zp);
    wait_row(5, "ovr_row5_timeout");
    tb2 = rand_tile(1);
    i_c = tb2; i_scale = sc + 16'd5; i_validResult = 1'b1;
    @(posedge i_clk); #1;
    i_validResult = 1'b0;
    @(negedge i_clk);
    check("ovr_pulse", o_overrun, 1);
    @(negedge i_clk);
    check("ovr_pulse_end", o_overrun, 0);
    wait_idle(100, "ovr_drain");

    // overrun on the cycle of the final handshake: dropped, no new tile starts
    t = rand_tile(0);
    push_model(t, 16'd9, 5'd2, 8'd0);
    pulse(t, 16'd9, 5'd2, 8'd0);
    wait_row(N - 1, "ovr_last_timeout");
    i_validResult = 1'b1;
    @(posedge i_clk); #1;
    i_validResult = 1'b0;
    @(negedge i_clk);
    check("ovr_last_pulse", o_overrun,    1);
    check("ovr_last_busy",  o_busy,       0);
    check("ovr_last_valid", rows.o_valid, 0);
    @(negedge i_clk);
    check("ovr_last_stays_idle", o_busy, 0);
    check("ovr_last_drained", exp_q.size(), 0);

    // reset mid-stream at row 7
    t = rand_tile(0);
    push_model(t, 16'd3, 5'd1, 8'd2);
    pulse(t, 16'd3, 5'd1, 8'd2);
    wait_row(7, "rst_row7_timeout");
    #2 i_arst_n = 1'b0;
    #1;
    check("mid_rst_valid", rows.o_valid, 0);
    check("mid_rst_busy",  o_busy,       0);
    check("mid_rst_row",   rows.o_row,   0);
    check("mid_rst_idx",   rows.o_rowIdx, 0);
    exp_q.delete();
    @(posedge i_clk); #3;
    i_arst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    check("post_rst_idle", o_busy, 0);
    t = rand_tile(0);
    push_model(t, 16'd1, 5'd0, 8'd0);
    pulse(t, 16'd1, 5'd0, 8'd0);
    wait_idle(100, "post_rst_drain");

    // randomized tiles with random backpressure
    ready_mode = 2;
    for (int k = 0; k < 8; k++) begin
      t  = rand_tile(k % 2);
      sc = 16'($urandom());
      sh = 5'($urandom_range(0, 31));
      zp = 8'($urandom());
      if (k % 2 == 0) sc = 16'($urandom_range(0, 64));
      push_model(t, sc, sh, zp);
      pulse(t, sc, sh, zp);
      wait_idle(400, "rand_drain");
    end
    ready_mode = 0;
    check("final_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/result_requant_drain.md
# result_requant_drain

Output stage directly downstream of `topSystolicArray`. It captures the N×N int32 result matrix on the array's single-cycle `o_validResult` pulse and requantizes each element to int8 using a latched scale, shift and zero point. It then streams the result one row per beat over a valid/ready interface toward the activation/writeback path. This frees the array to start the next tile while rows drain.

## Interface
- `N`, default 16: matrix dimension; must match the systolic array.
- `SCALE_W`, default 16: width of the unsigned requant multiplier.
- `i_clk`, in, 1: clock. All logic is rising-edge.
- `i_arst_n`, in, 1: asynchronous, active-low reset.
- `i_c`, in, `[N-1:0][N-1:0][31:0]`: signed int32 results. `i_c[i][j]` is row i, column j.
- `i_validResult`, in, 1: one-cycle pulse; `i_c` is valid in that cycle.
- `i_scale`, in, `SCALE_W`: unsigned multiplier.
- `i_shift`, in, 5: arithmetic right-shift amount, 0..31.
- `i_zeroPoint`, in, 8: signed int8 offset added after the shift.
- `o_row`, out, `[N-1:0][7:0]`: signed int8 row. `o_row[j]` is the requantized value of `c[rowIdx][j]`.
- `o_rowIdx`, out, `$clog2(N)`: index of the row currently on `o_row`.
- `o_valid`, out, 1: `o_row` is valid.
- `i_ready`, in, 1: consumer accepts the row.
- `o_last`, out, 1: high with `o_valid` when `o_rowIdx == N-1`.
- `o_busy`, out, 1: block is not in IDLE (combinational from state).
- `o_overrun`, out, 1: one-cycle pulse when an `i_validResult` is dropped.

## Operation
- **States:**
  - IDLE → FILL when `i_validResult` is sampled high.
  - FILL → STREAM unconditionally.
  - STREAM → IDLE on the handshake (`o_valid && i_ready`) of row N-1.
- **Capture (IDLE & `i_validResult`):**
  - Register all of `i_c` into an internal N×N×32 buffer.
  - Latch `i_scale`, `i_shift` and `i_zeroPoint`.
  - Changes to these inputs afterward have no effect on the tile in flight.
- **FILL:** load `o_row` with requantized row 0; set `o_rowIdx = 0` and `o_valid = 1`.
- **STREAM:**
  - On a handshake of row r < N-1, load row r+1 in the same edge. There is no bubble, and `o_valid` stays high.
  - On the handshake of row N-1, `o_valid` drops to 0.
  - While `o_valid && !i_ready`, `o_row`, `o_rowIdx` and `o_last` must hold stable.
- **Requant per element, with s = latched shift:**
  - p = c × scale, with c signed 32-bit and scale zero-extended; p is a 49-bit signed product.
  - If s > 0: q = (p + 2^(s-1)) >>> s. This rounds half toward +∞.
  - If s = 0: q = p.
  - y = q + sign-extended zero point, computed at full width.
  - Saturate y to [-128, 127]. No intermediate truncation is allowed before saturation.
- **Overrun:**
  - `i_validResult` sampled high in any state other than IDLE is ignored, and `o_overrun` pulses high for 1 cycle.
  - This includes the cycle of the final handshake.
  - Buffer and parameters are untouched, and the stream continues.

## Timing
- Reset values (asynchronous, while `i_arst_n = 0`):
  - `o_valid`, `o_last`, `o_busy`, `o_overrun` = 0.
  - `o_row` = 0 and `o_rowIdx` = 0.
  - State = IDLE.
  - Buffer contents are don't-care.
- Latency:
  - `i_validResult` sampled at edge E0.
  - `o_valid = 1` with row 0 after edge E1 (FILL occupies E0→E1).
- Throughput:
  - With `i_ready` held high, rows 0..N-1 occupy N consecutive cycles.
  - The block returns to IDLE after the edge accepting row N-1.
  - Minimum tile-to-tile interval is N+2 cycles.
- `o_busy` is high from the cycle after capture through the cycle of the final handshake.
- Reset mid-stream:
  - Outputs go to their reset values immediately.
  - After release, the block waits in IDLE. A partial tile is never resumed.

## Test plan
- **Basic stream:** `c[i][j] = i - j`, scale = 1, shift = 0, zp = 0, `i_ready = 1`.
  - Expect `o_row[j] = i - j` for rows 0..15 on 16 consecutive cycles.
  - First `o_valid` appears 2 edges after the pulse.
  - `o_last` is high only on row 15.
- **Rounding:** scale = 1.
  - c = 5, shift = 1 → 3.
  - c = -5, shift = 1 → -2.
  - c = -6, shift = 2 → -1.
  - c = 7, shift = 0, zp = -10 → -3.
- **Saturation:**
  - c = 1000, scale = 3, shift = 4 → 127.
  - c = -100000, scale = 1, shift = 0 → -128.
  - c = 20, zp = 120 → 127.
  - c = 2^31-1, scale = 65535, shift = 31 → 127. This checks for no product truncation.
- **Backpressure:** `i_ready` pattern 1,0,0,1,0,1… across the tile.
  - `o_row` and `o_rowIdx` must be stable during stalls.
  - Exactly 16 distinct rows are accepted, in order, with no duplicates.
- **Overrun:** second `i_validResult` pulse with different `i_c` and `i_scale` while row 5 is presented.
  - Expect a 1-cycle `o_overrun` pulse.
  - Rows 5..15 still come from the first tile with the first parameters.
- **Reset mid-stream:** assert `i_arst_n = 0` at row 7 between clock edges.
  - Expect `o_valid`, `o_busy` and `o_row` to be 0 immediately.
  - After release, a new pulse streams starting from `o_rowIdx = 0`.
